exec_alu_unit: RTL and testbench

Execute stage between the register file's read ports and its write port. It accepts two operands (Op1/Op2) plus an opcode and a destination select. It computes single-cycle ALU results, or an iterative multiply, then drives the register file's write-back triple WR / Sel_i1 / Ip1 for one cycle per instruction.

---
 rtl/exec_alu_pkg.sv | 48 ++++
 rtl/exec_alu_unit_if.sv | 28 ++
 rtl/exec_alu_unit_mul_iter.sv | 58 +++++
 rtl/exec_alu_unit.sv | 143 ++++++++++++++
 tb/tb_exec_alu_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/exec_alu_pkg.sv
// rtl/exec_alu_pkg.sv - opcodes, FSM state type and ALU helpers for exec_alu_unit
package exec_alu_pkg;

  localparam int DATA_W   = 32;
  localparam int SEL_W    = 4;
  localparam int MUL_ITER = 32;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  function automatic logic alu_legal(input logic [3:0] op);
    return (op <= OP_SRL);
  endfunction

  // Shift amount is always the low five bits of operand B.
  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_alu_unit_if.sv
// rtl/exec_alu_unit_if.sv - issue and register-file write-back bundle of exec_alu_unit
interface exec_alu_if;
  import exec_alu_pkg::*;

  logic              start;
  logic [3:0]        opcode;
  logic [SEL_W-1:0]  dest;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              done;
  logic              illegal;
  logic              zero;
  logic              wb_en;
  logic [SEL_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output start, opcode, dest, op_a, op_b,
    input  busy, done, illegal, zero, wb_en, wb_sel, wb_data
  );

  modport slave (
    input  start, opcode, dest, op_a, op_b,
    output busy, done, illegal, zero, wb_en, wb_sel, wb_data
  );

endinterface

// File: rtl/exec_alu_unit_mul_iter.sv
// rtl/exec_alu_unit_mul_iter.sv - iterative shift-add multiplier, one partial product per step
module mul_iter
  import exec_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] partial;

  // product already includes the current step, so the caller can register it on the last step
  assign partial = mplier_q[0] ? mcand_q : '0;
  assign product = acc_q + partial;
  assign last    = (cnt_q == 5'(MUL_ITER - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/exec_alu_unit.sv
// rtl/exec_alu_unit.sv - execute stage: single-cycle ALU plus iterative MUL, drives register-file write-back
// Define EXEC_ALU_MUL_EN to build the multiplier; otherwise opcode 8 retires as illegal.
module exec_alu_unit
  import exec_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  exec_alu_if.slave  bus
);

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              zero_q, zero_d;
  logic              wb_en_q, wb_en_d;
  logic [SEL_W-1:0]  wb_sel_q, wb_sel_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              fin;
  logic              fin_ill;
  logic [SEL_W-1:0]  fin_sel;
  logic [DATA_W-1:0] fin_data;
  logic [DATA_W-1:0] alu_res;

  assign alu_res = alu_calc(bus.opcode, bus.op_a, bus.op_b);

`ifdef EXEC_ALU_MUL_EN
  logic              mul_load;
  logic              mul_step;
  logic              mul_last;
  logic [DATA_W-1:0] mul_prod;
  logic [SEL_W-1:0]  dest_q, dest_d;

  mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.op_a),
    .b       (bus.op_b),
    .last    (mul_last),
    .product (mul_prod)
  );

  assign bus.busy = (state_q == MUL);
`else
  assign bus.busy = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    fin      = 1'b0;
    fin_ill  = 1'b0;
    fin_sel  = bus.dest;
    fin_data = alu_res;
`ifdef EXEC_ALU_MUL_EN
    mul_load = 1'b0;
    mul_step = 1'b0;
    dest_d   = dest_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef EXEC_ALU_MUL_EN
          if (bus.opcode == OP_MUL) begin
            mul_load = 1'b1;
            dest_d   = bus.dest;
            state_d  = MUL;
          end else
`endif
          begin
            fin     = 1'b1;
            fin_ill = !alu_legal(bus.opcode);
          end
        end
      end
`ifdef EXEC_ALU_MUL_EN
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          fin      = 1'b1;
          fin_sel  = dest_q;
          fin_data = mul_prod;
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Retire path shared by single-cycle ops and the multiplier; r0 is never written.
  always_comb begin
    done_d    = 1'b0;
    illegal_d = 1'b0;
    wb_en_d   = 1'b0;
    wb_sel_d  = wb_sel_q;
    wb_data_d = wb_data_q;
    zero_d    = zero_q;
    if (fin) begin
      done_d    = 1'b1;
      illegal_d = fin_ill;
      wb_sel_d  = fin_sel;
      wb_data_d = fin_ill ? '0 : fin_data;
      zero_d    = fin_ill ? 1'b1 : (fin_data == '0);
      wb_en_d   = !fin_ill && (fin_sel != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      zero_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
`ifdef EXEC_ALU_MUL_EN
      dest_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      zero_q    <= zero_d;
      wb_en_q   <= wb_en_d;
      wb_sel_q  <= wb_sel_d;
      wb_data_q <= wb_data_d;
`ifdef EXEC_ALU_MUL_EN
      dest_q    <= dest_d;
`endif
    end
  end

  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.zero    = zero_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_sel  = wb_sel_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_exec_alu_unit.sv
// tb/tb_exec_alu_unit.sv - directed self-checking bench for exec_alu_unit
module tb_exec_alu_unit;
  import exec_alu_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  exec_alu_if bus ();

  exec_alu_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] op, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.dest   = d;
    bus.op_a   = a;
    bus.op_b   = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue(OP_ADD, 4'd3, 32'd1, 32'd2);
    repeat (2) @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL reset_wb_en got=%b want=0", bus.wb_en); end
    total++; if (bus.wb_data !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%h want=0", bus.wb_data); end
    total++; if (bus.wb_sel !== 4'h0) begin bad++; $display("FAIL reset_wb_sel got=%h want=0", bus.wb_sel); end
    total++; if ({bus.busy, bus.zero, bus.illegal} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.zero, bus.illegal}); end
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_start_dropped got=%b want=0", bus.done); end
  endtask

  task automatic test_add();
    issue(OP_ADD, 4'd2, 32'hAAAA_BBBB, 32'h1234_5678);
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL add_done got=%b want=1", bus.done); end
    total++; if (bus.wb_en !== 1'b1) begin bad++; $display("FAIL add_wb_en got=%b want=1", bus.wb_en); end
    total++; if (bus.wb_sel !== 4'd2) begin bad++; $display("FAIL add_wb_sel got=%h want=2", bus.wb_sel); end
    total++; if (bus.wb_data !== 32'hBCDF_1233) begin bad++; $display("FAIL add_wb_data got=%h want=bcdf1233", bus.wb_data); end
    total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b want=0", bus.zero); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.wb_en !== 1'b0) begin bad++; $display("FAIL add_pulse got=%b%b want=00", bus.done, bus.wb_en); end
    total++; if (bus.wb_data !== 32'hBCDF_1233) begin bad++; $display("FAIL add_hold got=%h want=bcdf1233", bus.wb_data); end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  task automatic test_back_to_back();
    vec_t v[9];
    v[0] = '{OP_SUB, 4'd5,  32'd5,          32'd5,          32'h0000_0000};
    v[1] = '{OP_SLT, 4'd1,  32'hFFFF_FFFF,  32'd1,          32'h0000_0001};
    v[2] = '{OP_SRL, 4'd3,  32'h8000_0000,  32'd31,         32'h0000_0001};
    v[3] = '{OP_AND, 4'd4,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
    v[4] = '{OP_OR,  4'd6,  32'h0F00_0000,  32'h0000_00F0,  32'h0F00_00F0};
    v[5] = '{OP_XOR, 4'd8,  32'hFFFF_0000,  32'hFF00_FF00,  32'h00FF_FF00};
    v[6] = '{OP_SLL, 4'd9,  32'h0000_0001,  32'h0000_0024,  32'h0000_0010};
    v[7] = '{OP_ADD, 4'd10, 32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000};
    v[8] = '{OP_SLT, 4'd11, 32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      issue(v[i].op, v[i].d, v[i].a, v[i].b);
      @(negedge clk);
      total++;
      if (bus.done !== 1'b1 || bus.wb_en !== 1'b1 || bus.wb_sel !== v[i].d ||
          bus.wb_data !== v[i].res || bus.zero !== (v[i].res == 32'h0)) begin
        bad++;
        $display("FAIL b2b_%0d got done=%b en=%b sel=%h data=%h zero=%b want sel=%h data=%h",
                 i, bus.done, bus.wb_en, bus.wb_sel, bus.wb_data, bus.zero, v[i].d, v[i].res);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dest0();
    issue(OP_ADD, 4'd0, 32'd1, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL dest0_done got=%b want=1", bus.done); end
    total++; if (bus.wb_data !== 32'd2) begin bad++; $display("FAIL dest0_data got=%h want=2", bus.wb_data); end
    total++; if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL dest0_wb_en got=%b want=0", bus.wb_en); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    issue(4'd12, 4'd5, 32'h1234_0000, 32'h0000_5678);
    @(negedge clk);
    bus.start = 1'b0;
    total++; if ({bus.done, bus.illegal, bus.wb_en} !== 3'b110) begin bad++; $display("FAIL illegal_flags got=%b want=110", {bus.done, bus.illegal, bus.wb_en}); end
    total++; if (bus.wb_data !== 32'h0 || bus.zero !== 1'b1) begin bad++; $display("FAIL illegal_data got=%h/%b want=0/1", bus.wb_data, bus.zero); end
    @(negedge clk);
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%b want=0", bus.illegal); end
  endtask

  task automatic test_mul();
`ifdef EXEC_ALU_MUL_EN
    int cyc;
    issue(OP_MUL, 4'd7, 32'h0001_0003, 32'h0000_0010);
    @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL mul_busy got=%b%b want=10", bus.busy, bus.done); end
    issue(OP_ADD, 4'd9, 32'hDEAD_0000, 32'h0000_BEEF);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) break;
    end
    total++; if (cyc !== 32) begin bad++; $display("FAIL mul_latency got=%0d want=32", cyc); end
    total++; if (bus.wb_data !== 32'h0010_0030) begin bad++; $display("FAIL mul_data got=%h want=00100030", bus.wb_data); end
    total++; if (bus.wb_sel !== 4'd7 || bus.wb_en !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL mul_wb got sel=%h en=%b busy=%b want 7/1/0", bus.wb_sel, bus.wb_en, bus.busy); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mul_ignored_start got=%b want=0", bus.done); end
`else
    issue(OP_MUL, 4'd7, 32'h0001_0003, 32'h0000_0010);
    @(negedge clk);
    bus.start = 1'b0;
    total++; if ({bus.done, bus.illegal, bus.wb_en, bus.busy} !== 4'b1100) begin bad++; $display("FAIL mul_off got=%b want=1100", {bus.done, bus.illegal, bus.wb_en, bus.busy}); end
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_abort();
`ifdef EXEC_ALU_MUL_EN
    int seen;
    issue(OP_MUL, 4'd7, 32'h0000_0005, 32'h0000_0006);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.wb_en === 1'b1 || bus.busy === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_activity got=%0d want=0", seen); end
`endif
    issue(OP_ADD, 4'd4, 32'd40, 32'd2);
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.done !== 1'b1 || bus.wb_en !== 1'b1 || bus.wb_data !== 32'd42 || bus.wb_sel !== 4'd4) begin
      bad++; $display("FAIL post_reset_add got done=%b en=%b data=%h sel=%h want 1/1/2a/4", bus.done, bus.wb_en, bus.wb_data, bus.wb_sel);
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.opcode = 4'd0;
    bus.dest = 4'd0;
    bus.op_a = 32'd0;
    bus.op_b = 32'd0;
    @(negedge clk);
    test_reset();
    test_add();
    test_back_to_back();
    test_dest0();
    test_illegal();
    test_mul();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
